// File: rtl/rggen_w01t_hw_pkg.sv
// rtl/rggen_w01t_hw_pkg.sv - toggle mode encoding and per-bit toggle select helper
package rggen_w01t_hw_pkg;

    typedef enum logic [1:0] {
        W01T_MODE_W0T,
        W01T_MODE_W1T,
        W01T_MODE_WT
    } w01t_mode_e;

    localparam int W01T_MAX_WIDTH = 64;

    // Decide whether one written data bit requests a toggle under the given mode.
    // The write mask is applied by the caller.
    function automatic logic sel_toggle(input w01t_mode_e mode, input logic data);
        logic sel;
        case (mode)
            W01T_MODE_W0T: sel = ~data;
            W01T_MODE_W1T: sel = data;
            default:       sel = 1'b1;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/rggen_bit_field_if.sv
// rtl/rggen_bit_field_if.sv - register-slice to bit-field access interface
interface rggen_bit_field_if #(
    parameter int WIDTH = 1
);
    logic             valid;
    logic [WIDTH-1:0] write_mask;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] read_data;
    logic [WIDTH-1:0] value;

    modport bit_field (
        input  valid,
        input  write_mask,
        input  write_data,
        output read_data,
        output value
    );

    modport master (
        output valid,
        output write_mask,
        output write_data,
        input  read_data,
        input  value
    );
endinterface

// File: rtl/rggen_bit_field_w01t_hw_bit.sv
// rtl/rggen_bit_field_w01t_hw_bit.sv - one bit of the toggle field: priority mux, value and change flops
module rggen_bit_field_w01t_hw_bit #(
    parameter bit INITIAL_VALUE = 1'b0,
    parameter bit CHANGE_STICKY = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sw_toggle,
    input  logic i_hw_set,
    input  logic i_hw_clear,
    input  logic i_hw_toggle,
    input  logic i_rd_clr,
    output logic o_value,
    output logic o_changed
);

    logic value_d;
    logic value_q;
    logic changed_d;
    logic changed_q;
    logic diff;

    // Next value: clear beats set, both beat toggle; sw and hw toggles merge into one flip.
    always_comb begin
        value_d = value_q;
        if (i_hw_clear) begin
            value_d = 1'b0;
        end else if (i_hw_set) begin
            value_d = 1'b1;
        end else if (i_sw_toggle || i_hw_toggle) begin
            value_d = ~value_q;
        end
    end

    assign diff = value_d ^ value_q;

    // Change flag: a pulse, or a sticky flag where a fresh change outranks the read-clear.
    always_comb begin
        changed_d = diff;
        if (CHANGE_STICKY) begin
            changed_d = (changed_q & ~i_rd_clr) | diff;
        end
    end

    // State registers with asynchronous reset to the field's initial value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            value_q   <= INITIAL_VALUE;
            changed_q <= 1'b0;
        end else begin
            value_q   <= value_d;
            changed_q <= changed_d;
        end
    end

    assign o_value   = value_q;
    assign o_changed = changed_q;

endmodule

// File: rtl/rggen_bit_field_w01t_hw.sv
// rtl/rggen_bit_field_w01t_hw.sv - toggle-on-write bit field with hw set/clear/toggle; optional RGGEN_BIT_FIELD_W01T_HW_LOCK_EN adds i_lock
module rggen_bit_field_w01t_hw
    import rggen_w01t_hw_pkg::*;
#(
    parameter w01t_mode_e       TOGGLE_MODE   = W01T_MODE_W1T,
    parameter int               WIDTH         = 1,
    parameter bit [WIDTH-1:0]   INITIAL_VALUE = '0,
    parameter bit               CHANGE_STICKY = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    rggen_bit_field_if.bit_field  bit_field_if,
    input  logic [WIDTH-1:0]      i_hw_set,
    input  logic [WIDTH-1:0]      i_hw_clear,
    input  logic [WIDTH-1:0]      i_hw_toggle,
`ifdef RGGEN_BIT_FIELD_W01T_HW_LOCK_EN
    input  logic                  i_lock,
`endif
    output logic [WIDTH-1:0]      o_value,
    output logic [WIDTH-1:0]      o_changed
);

    logic             sw_enable;
    logic [WIDTH-1:0] sw_toggle;
    logic [WIDTH-1:0] rd_clr;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] changed;

    // Software write qualification; the lock only silences software, never hardware.
    always_comb begin
        sw_enable = bit_field_if.valid;
`ifdef RGGEN_BIT_FIELD_W01T_HW_LOCK_EN
        if (i_lock) begin
            sw_enable = 1'b0;
        end
`endif
    end

    // Decode written data into per-bit toggle requests according to the toggle mode.
    always_comb begin
        sw_toggle = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sw_toggle[i] = sw_enable & bit_field_if.write_mask[i] &
                           sel_toggle(TOGGLE_MODE, bit_field_if.write_data[i]);
        end
    end

    // A mask-free access is a read; it clears sticky change flags.
    always_comb begin
        rd_clr = '0;
        if (bit_field_if.valid && (bit_field_if.write_mask == '0)) begin
            rd_clr = '1;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        rggen_bit_field_w01t_hw_bit #(
            .INITIAL_VALUE (INITIAL_VALUE[g]),
            .CHANGE_STICKY (CHANGE_STICKY)
        ) u_bit (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_sw_toggle (sw_toggle[g]),
            .i_hw_set    (i_hw_set[g]),
            .i_hw_clear  (i_hw_clear[g]),
            .i_hw_toggle (i_hw_toggle[g]),
            .i_rd_clr    (rd_clr[g]),
            .o_value     (value[g]),
            .o_changed   (changed[g])
        );
    end

    assign bit_field_if.read_data = value;
    assign bit_field_if.value     = value;
    assign o_value                = value;
    assign o_changed              = changed;

endmodule

// File: tb/tb_rggen_bit_field_w01t_hw.sv
// tb/tb_rggen_bit_field_w01t_hw.sv - directed self-checking bench for the toggle bit field
module tb_rggen_bit_field_w01t_hw;
    import rggen_w01t_hw_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [7:0] set_a, clr_a, tgl_a, val_a, chg_a;
    logic [7:0] set_b, clr_b, tgl_b, val_b, chg_b;
    logic [7:0] set_c, clr_c, tgl_c, val_c, chg_c;
    logic       lock_a, lock_b, lock_c;

    rggen_bit_field_if #(.WIDTH(8)) if_a ();
    rggen_bit_field_if #(.WIDTH(8)) if_b ();
    rggen_bit_field_if #(.WIDTH(8)) if_c ();

    rggen_bit_field_w01t_hw #(
        .TOGGLE_MODE(W01T_MODE_W1T), .WIDTH(8), .INITIAL_VALUE(8'hA5), .CHANGE_STICKY(1'b0)
    ) dut_w1t (
        .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(if_a),
        .i_hw_set(set_a), .i_hw_clear(clr_a), .i_hw_toggle(tgl_a),
`ifdef RGGEN_BIT_FIELD_W01T_HW_LOCK_EN
        .i_lock(lock_a),
`endif
        .o_value(val_a), .o_changed(chg_a)
    );

    rggen_bit_field_w01t_hw #(
        .TOGGLE_MODE(W01T_MODE_W0T), .WIDTH(8), .INITIAL_VALUE(8'hFF), .CHANGE_STICKY(1'b0)
    ) dut_w0t (
        .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(if_b),
        .i_hw_set(set_b), .i_hw_clear(clr_b), .i_hw_toggle(tgl_b),
`ifdef RGGEN_BIT_FIELD_W01T_HW_LOCK_EN
        .i_lock(lock_b),
`endif
        .o_value(val_b), .o_changed(chg_b)
    );

    rggen_bit_field_w01t_hw #(
        .TOGGLE_MODE(W01T_MODE_WT), .WIDTH(8), .INITIAL_VALUE(8'h00), .CHANGE_STICKY(1'b1)
    ) dut_wt (
        .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(if_c),
        .i_hw_set(set_c), .i_hw_clear(clr_c), .i_hw_toggle(tgl_c),
`ifdef RGGEN_BIT_FIELD_W01T_HW_LOCK_EN
        .i_lock(lock_c),
`endif
        .o_value(val_c), .o_changed(chg_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        set_a = '0; clr_a = '0; tgl_a = '0;
        set_b = '0; clr_b = '0; tgl_b = '0;
        set_c = '0; clr_c = '0; tgl_c = '0;
        lock_a = 1'b0; lock_b = 1'b0; lock_c = 1'b0;
        if_a.valid = 1'b0; if_a.write_mask = '0; if_a.write_data = '0;
        if_b.valid = 1'b0; if_b.write_mask = '0; if_b.write_data = '0;
        if_c.valid = 1'b0; if_c.write_mask = '0; if_c.write_data = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_all();
        tick();
        tick();
        total++; if (val_a !== 8'hA5) begin bad++; $display("FAIL reset_value act=%h exp=a5", val_a); end
        total++; if (chg_a !== 8'h00) begin bad++; $display("FAIL reset_changed act=%h exp=00", chg_a); end
        total++; if (if_a.read_data !== 8'hA5) begin bad++; $display("FAIL reset_read_data act=%h exp=a5", if_a.read_data); end
        total++; if (if_a.value !== 8'hA5) begin bad++; $display("FAIL reset_if_value act=%h exp=a5", if_a.value); end
        total++; if (val_b !== 8'hFF) begin bad++; $display("FAIL reset_w0t_value act=%h exp=ff", val_b); end
        total++; if (val_c !== 8'h00 || chg_c !== 8'h00) begin bad++; $display("FAIL reset_wt act=%h/%h exp=00/00", val_c, chg_c); end
        rst_n = 1'b1;
        tick();
        total++; if (val_a !== 8'hA5) begin bad++; $display("FAIL reset_release_hold act=%h exp=a5", val_a); end
    endtask

    task automatic test_w1t();
        clr_a = 8'hFF;
        tick();
        clr_a = 8'h00;
        total++; if (val_a !== 8'h00 || chg_a !== 8'hA5) begin bad++; $display("FAIL hw_clear act=%h/%h exp=00/a5", val_a, chg_a); end
        if_a.valid = 1'b1; if_a.write_mask = 8'hFF; if_a.write_data = 8'h0F;
        tick();
        if_a.valid = 1'b0;
        total++; if (val_a !== 8'h0F || chg_a !== 8'h0F) begin bad++; $display("FAIL w1t_first act=%h/%h exp=0f/0f", val_a, chg_a); end
        tick();
        total++; if (val_a !== 8'h0F || chg_a !== 8'h00) begin bad++; $display("FAIL w1t_pulse_end act=%h/%h exp=0f/00", val_a, chg_a); end
        if_a.valid = 1'b1;
        tick();
        if_a.valid = 1'b0;
        total++; if (val_a !== 8'h00 || chg_a !== 8'h0F) begin bad++; $display("FAIL w1t_second act=%h/%h exp=00/0f", val_a, chg_a); end
    endtask

    task automatic test_w0t();
        if_b.valid = 1'b1; if_b.write_mask = 8'h3C; if_b.write_data = 8'hF0;
        tick();
        total++; if (val_b !== 8'hF3 || chg_b !== 8'h0C) begin bad++; $display("FAIL w0t_write act=%h/%h exp=f3/0c", val_b, chg_b); end
        if_b.write_mask = 8'h00; if_b.write_data = 8'h00;
        tick();
        if_b.valid = 1'b0;
        total++; if (val_b !== 8'hF3 || chg_b !== 8'h00) begin bad++; $display("FAIL w0t_mask_zero act=%h/%h exp=f3/00", val_b, chg_b); end
    endtask

    task automatic test_wt_sticky();
        if_c.valid = 1'b1; if_c.write_mask = 8'h01; if_c.write_data = 8'h00;
        tick();
        if_c.valid = 1'b0;
        total++; if (val_c !== 8'h01 || chg_c !== 8'h01) begin bad++; $display("FAIL wt_write act=%h/%h exp=01/01", val_c, chg_c); end
        tick();
        total++; if (chg_c !== 8'h01) begin bad++; $display("FAIL sticky_hold act=%h exp=01", chg_c); end
        if_c.valid = 1'b1; if_c.write_mask = 8'h00;
        tick();
        if_c.valid = 1'b0;
        total++; if (val_c !== 8'h01 || chg_c !== 8'h00) begin bad++; $display("FAIL sticky_read_clear act=%h/%h exp=01/00", val_c, chg_c); end
        tgl_c = 8'h01;
        tick();
        tgl_c = 8'h00;
        total++; if (val_c !== 8'h00 || chg_c !== 8'h01) begin bad++; $display("FAIL sticky_hw_toggle act=%h/%h exp=00/01", val_c, chg_c); end
        if_c.valid = 1'b1; if_c.write_mask = 8'h00; tgl_c = 8'h01;
        tick();
        if_c.valid = 1'b0; tgl_c = 8'h00;
        total++; if (val_c !== 8'h01 || chg_c !== 8'h01) begin bad++; $display("FAIL sticky_read_vs_change act=%h/%h exp=01/01", val_c, chg_c); end
        tgl_c = 8'h02;
        tick();
        tgl_c = 8'h04;
        tick();
        tgl_c = 8'h00;
        total++; if (val_c !== 8'h07 || chg_c !== 8'h07) begin bad++; $display("FAIL sticky_accumulate act=%h/%h exp=07/07", val_c, chg_c); end
        if_c.valid = 1'b1; if_c.write_mask = 8'h00;
        tick();
        if_c.valid = 1'b0;
        total++; if (chg_c !== 8'h00) begin bad++; $display("FAIL sticky_final_clear act=%h exp=00", chg_c); end
    endtask

    task automatic test_priority();
        if_a.valid = 1'b1; if_a.write_mask = 8'hFF; if_a.write_data = 8'h0A;
        tgl_a = 8'h08; set_a = 8'h06; clr_a = 8'h04;
        tick();
        total++; if (val_a !== 8'h0A || chg_a !== 8'h0A) begin bad++; $display("FAIL priority_first act=%h/%h exp=0a/0a", val_a, chg_a); end
        tick();
        if_a.valid = 1'b0; tgl_a = '0; set_a = '0; clr_a = '0;
        total++; if (val_a !== 8'h02 || chg_a !== 8'h08) begin bad++; $display("FAIL priority_second act=%h/%h exp=02/08", val_a, chg_a); end
    endtask

    task automatic test_back_to_back();
        if_a.valid = 1'b1; if_a.write_mask = 8'hF0; if_a.write_data = 8'h30;
        tick();
        total++; if (val_a !== 8'h32) begin bad++; $display("FAIL b2b_first act=%h exp=32", val_a); end
        if_a.write_data = 8'hC0;
        tick();
        total++; if (val_a !== 8'hF2) begin bad++; $display("FAIL b2b_second act=%h exp=f2", val_a); end
        if_a.write_mask = 8'h0F; if_a.write_data = 8'hFF;
        tick();
        if_a.valid = 1'b0;
        total++; if (val_a !== 8'hFD || chg_a !== 8'h0F) begin bad++; $display("FAIL b2b_third act=%h/%h exp=fd/0f", val_a, chg_a); end
    endtask

`ifdef RGGEN_BIT_FIELD_W01T_HW_LOCK_EN
    task automatic test_lock();
        clr_a = 8'hFF;
        tick();
        clr_a = 8'h00;
        lock_a = 1'b1;
        if_a.valid = 1'b1; if_a.write_mask = 8'hFF; if_a.write_data = 8'hFF;
        tick();
        total++; if (val_a !== 8'h00) begin bad++; $display("FAIL lock_blocks_sw act=%h exp=00", val_a); end
        total++; if (if_a.read_data !== 8'h00) begin bad++; $display("FAIL lock_read_data act=%h exp=00", if_a.read_data); end
        set_a = 8'h80;
        tick();
        set_a = 8'h00;
        total++; if (val_a !== 8'h80) begin bad++; $display("FAIL lock_hw_set act=%h exp=80", val_a); end
        if_a.valid = 1'b0; lock_a = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        tgl_a = 8'hFF; tgl_c = 8'h10;
        tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (val_a !== 8'hA5 || chg_a !== 8'h00) begin bad++; $display("FAIL reset_mid_a act=%h/%h exp=a5/00", val_a, chg_a); end
        total++; if (val_c !== 8'h00 || chg_c !== 8'h00) begin bad++; $display("FAIL reset_mid_c act=%h/%h exp=00/00", val_c, chg_c); end
        tick();
        idle_all();
        #2;
        rst_n = 1'b1;
        tick();
        total++; if (val_a !== 8'hA5 || chg_a !== 8'h00) begin bad++; $display("FAIL reset_mid_after act=%h/%h exp=a5/00", val_a, chg_a); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_w1t();
        test_w0t();
        test_wt_sticky();
        test_priority();
        test_back_to_back();
`ifdef RGGEN_BIT_FIELD_W01T_HW_LOCK_EN
        test_lock();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
